// File: rtl/rfseq_pkg.sv
// rtl/rfseq_pkg.sv - shared constants, state encoding and select decode for regfile_sequencer
// Contents: opcode constants, FunSel constants, FSM state enum, NONE_SEL,
//           addr_to_sel() mapping a 3-bit register address to active-low (RegSel, ScrSel).
package rfseq_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_CLR = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_SWP = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLEAR = 3'b011;

  localparam logic [3:0] NONE_SEL = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_SWP_RD = 3'd2,
    ST_SWP_W1 = 3'd3,
    ST_SWP_W2 = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] regsel;
    logic [3:0] scrsel;
  } sel_pair_t;

  // Address 0..3 -> R1..R4 on RegSel bit3..bit0; 4..7 -> S1..S4 on ScrSel bit3..bit0.
  function automatic sel_pair_t addr_to_sel(input logic [2:0] addr);
    sel_pair_t  p;
    logic [3:0] cold;
    cold     = ~(4'b1000 >> addr[1:0]);
    p.regsel = addr[2] ? NONE_SEL : cold;
    p.scrsel = addr[2] ? cold : NONE_SEL;
    return p;
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - command handshake bundle between decoder and sequencer
// Signals: cmd_valid/cmd_ready handshake, cmd_op/cmd_dst/cmd_src/cmd_imm payload,
//          done/err completion pulses. master = decoder side, slave = sequencer side.
interface regfile_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [2:0]        cmd_dst;
  logic [2:0]        cmd_src;
  logic [DATA_W-1:0] cmd_imm;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
    input  cmd_ready, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
    output cmd_ready, done, err
  );
endinterface

// File: rtl/rfseq_sel_decode.sv
// rtl/rfseq_sel_decode.sv - write-address to active-low RegSel/ScrSel decode
// Ports: wr_en (1 = strobe one select low), wr_addr (3-bit register address),
//        regsel/scrsel (active-low one-cold selects, 1111 when wr_en is 0).
module rfseq_sel_decode
  import rfseq_pkg::*;
(
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  output logic [3:0] regsel,
  output logic [3:0] scrsel
);

  sel_pair_t pair;

  always_comb begin
    pair = addr_to_sel(wr_addr);
    if (!wr_en) pair = {NONE_SEL, NONE_SEL};
  end

  assign regsel = pair.regsel;
  assign scrsel = pair.scrsel;

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - micro-op sequencer driving the 8-entry register file
// Ports: Clock, Reset (sync, active-low), cmd (slave command handshake),
//        FunSel/RegSel/ScrSel/OutASel/OutBSel (registered regfile controls),
//        I (combinational write data), OutA/OutB (regfile read ports).
// Optional: RFSEQ_STATS_EN adds cmd_count (16-bit) and swp_count (8-bit) saturating counters.
module regfile_sequencer
  import rfseq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  regfile_sequencer_if.slave cmd,
  output logic [2:0]        FunSel,
  output logic [3:0]        RegSel,
  output logic [3:0]        ScrSel,
  output logic [2:0]        OutASel,
  output logic [2:0]        OutBSel,
  output logic [DATA_W-1:0] I,
  input  logic [DATA_W-1:0] OutA,
  input  logic [DATA_W-1:0] OutB
`ifdef RFSEQ_STATS_EN
  ,
  output logic [15:0]       cmd_count,
  output logic [7:0]        swp_count
`endif
);

  state_t            state, state_n;
  logic [2:0]        op_q, src_q, dst_q;
  logic [DATA_W-1:0] imm_q, tmp_a, tmp_b;

  logic              accept;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [2:0]        funsel_n, asel_n, bsel_n;
  logic              done_n, err_n;
  logic [3:0]        regsel_n, scrsel_n;

  assign accept = (state == ST_IDLE) && cmd.cmd_ready && cmd.cmd_valid;

  // Next-state and next-output logic; outputs are registered so the values
  // computed here appear during the state being entered.
  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    wr_addr  = dst_q;
    funsel_n = FS_LOAD;
    asel_n   = OutASel;
    bsel_n   = OutBSel;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          wr_addr = cmd.cmd_dst;
          if (cmd.cmd_op == OP_SWP && cmd.cmd_src != cmd.cmd_dst) begin
            state_n = ST_SWP_RD;
            asel_n  = cmd.cmd_src;
            bsel_n  = cmd.cmd_dst;
          end else begin
            // Degenerate swap (src == dst) falls into the no-write default below.
            state_n = ST_EXEC;
            done_n  = 1'b1;
            err_n   = (cmd.cmd_op == OP_ILL);
            case (cmd.cmd_op)
              OP_CLR: begin wr_en = 1'b1; funsel_n = FS_CLEAR; end
              OP_LDI: begin wr_en = 1'b1; funsel_n = FS_LOAD;  end
              OP_INC: begin wr_en = 1'b1; funsel_n = FS_INC;   end
              OP_DEC: begin wr_en = 1'b1; funsel_n = FS_DEC;   end
              OP_MOV: begin wr_en = 1'b1; funsel_n = FS_LOAD; asel_n = cmd.cmd_src; end
              default: ;
            endcase
          end
        end
      end
      ST_EXEC:   state_n = ST_IDLE;
      ST_SWP_RD: begin
        state_n = ST_SWP_W1;
        wr_en   = 1'b1;
        wr_addr = dst_q;
      end
      ST_SWP_W1: begin
        state_n = ST_SWP_W2;
        wr_en   = 1'b1;
        wr_addr = src_q;
        done_n  = 1'b1;
      end
      ST_SWP_W2: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  rfseq_sel_decode u_sel_decode (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .regsel  (regsel_n),
    .scrsel  (scrsel_n)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state         <= ST_IDLE;
      cmd.cmd_ready <= 1'b0;
      cmd.done      <= 1'b0;
      cmd.err       <= 1'b0;
      FunSel        <= FS_LOAD;
      RegSel        <= NONE_SEL;
      ScrSel        <= NONE_SEL;
      OutASel       <= '0;
      OutBSel       <= '0;
      op_q          <= OP_NOP;
      src_q         <= '0;
      dst_q         <= '0;
      imm_q         <= '0;
      tmp_a         <= '0;
      tmp_b         <= '0;
    end else begin
      state         <= state_n;
      cmd.cmd_ready <= (state_n == ST_IDLE);
      cmd.done      <= done_n;
      cmd.err       <= err_n;
      FunSel        <= funsel_n;
      RegSel        <= regsel_n;
      ScrSel        <= scrsel_n;
      OutASel       <= asel_n;
      OutBSel       <= bsel_n;
      if (accept) begin
        op_q  <= cmd.cmd_op;
        src_q <= cmd.cmd_src;
        dst_q <= cmd.cmd_dst;
        imm_q <= cmd.cmd_imm;
      end
      // Both operands are read in SWP_RD so the first write cannot corrupt the second.
      if (state == ST_SWP_RD) begin
        tmp_a <= OutA;
        tmp_b <= OutB;
      end
    end
  end

  always_comb begin
    I = '0;
    case (state)
      ST_EXEC: begin
        if (op_q == OP_MOV)      I = OutA;
        else if (op_q == OP_LDI) I = imm_q;
      end
      ST_SWP_W1: I = tmp_a;
      ST_SWP_W2: I = tmp_b;
      default:   I = '0;
    endcase
  end

`ifdef RFSEQ_STATS_EN
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cmd_count <= '0;
      swp_count <= '0;
    end else begin
      if (cmd.done && cmd_count != 16'hFFFF) cmd_count <= cmd_count + 16'd1;
      if (cmd.done && state == ST_SWP_W2 && swp_count != 8'hFF) swp_count <= swp_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - self-checking bench for regfile_sequencer with a register-file model
module tb_regfile_sequencer;
  import rfseq_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [2:0]    FunSel;
  logic [3:0]    RegSel, ScrSel;
  logic [2:0]    OutASel, OutBSel;
  logic [DW-1:0] I, OutA, OutB;
`ifdef RFSEQ_STATS_EN
  logic [15:0]   cmd_count;
  logic [7:0]    swp_count;
`endif

  always #5 clk = ~clk;

  regfile_sequencer_if #(.DATA_W(DW)) cif ();

  regfile_sequencer #(.DATA_W(DW)) dut (
    .Clock   (clk),
    .Reset   (rstn),
    .cmd     (cif),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .I       (I),
    .OutA    (OutA),
    .OutB    (OutB)
`ifdef RFSEQ_STATS_EN
    ,
    .cmd_count (cmd_count),
    .swp_count (swp_count)
`endif
  );

  // Register file model: combinational reads, writes on rising edge.
  logic [DW-1:0] rf [8];
  assign OutA = rf[OutASel];
  assign OutB = rf[OutBSel];

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if ((k < 4) ? !RegSel[3-k] : !ScrSel[7-k]) begin
        case (FunSel)
          3'b000:  rf[k] <= rf[k] - 16'd1;
          3'b001:  rf[k] <= rf[k] + 16'd1;
          3'b010:  rf[k] <= I;
          3'b011:  rf[k] <= '0;
          default: rf[k] <= rf[k];
        endcase
      end
    end
  end

  typedef struct packed {
    logic [3:0]  regsel;
    logic [3:0]  scrsel;
    logic [2:0]  funsel;
    logic        chk_fs;
    logic [15:0] i;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  op, dst, src;
    logic [15:0] imm, pre_src, pre_dst, res;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] r, input logic [3:0] s, input logic [2:0] fs,
                              input logic c, input logic [15:0] i, input logic er);
    exp_t e;
    e.regsel = r; e.scrsel = s; e.funsel = fs; e.chk_fs = c; e.i = i; e.err = er;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                               input logic [15:0] imm, input logic [15:0] ps, input logic [15:0] pd,
                               input logic [15:0] res, input exp_t e);
    vec_t v;
    v.op = op; v.dst = dst; v.src = src; v.imm = imm;
    v.pre_src = ps; v.pre_dst = pd; v.res = res; v.e = e;
    return v;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && cif.done === 1'b1) begin
      exp_t e;
      dones++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk("done_regsel", RegSel, e.regsel);
        chk("done_scrsel", ScrSel, e.scrsel);
        chk("done_I", I, e.i);
        chk("done_err", cif.err, e.err);
        if (e.chk_fs) chk("done_funsel", FunSel, e.funsel);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [15:0] imm, input exp_t e);
    int n = 0;
    while (cif.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_cmd", cif.cmd_ready, 1);
    sb.push_back(e);
    cif.cmd_op    = op;
    cif.cmd_dst   = dst;
    cif.cmd_src   = src;
    cif.cmd_imm   = imm;
    cif.cmd_valid = 1'b1;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cif.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_after_cmd", cif.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[11];

  initial begin
    int busy;
    int d0;
    int accepts;

    vecs[0]  = mkv(OP_LDI, 3'd2, 3'd0, 16'hA5A5, 16'h0,    16'h0,    16'hA5A5, mk(4'b1101, 4'b1111, FS_LOAD,  1, 16'hA5A5, 0));
    vecs[1]  = mkv(OP_MOV, 3'd5, 3'd0, 16'h0,    16'h1234, 16'h0,    16'h1234, mk(4'b1111, 4'b1011, FS_LOAD,  1, 16'h1234, 0));
    vecs[2]  = mkv(OP_INC, 3'd3, 3'd0, 16'h0,    16'h0,    16'hFFFF, 16'h0000, mk(4'b1110, 4'b1111, FS_INC,   1, 16'h0,    0));
    vecs[3]  = mkv(OP_DEC, 3'd7, 3'd0, 16'h0,    16'h0,    16'h0000, 16'hFFFF, mk(4'b1111, 4'b1110, FS_DEC,   1, 16'h0,    0));
    vecs[4]  = mkv(OP_CLR, 3'd4, 3'd0, 16'h0,    16'h0,    16'h5555, 16'h0000, mk(4'b1111, 4'b0111, FS_CLEAR, 1, 16'h0,    0));
    vecs[5]  = mkv(OP_NOP, 3'd1, 3'd0, 16'h0,    16'h0,    16'h7777, 16'h7777, mk(4'b1111, 4'b1111, FS_LOAD,  0, 16'h0,    0));
    vecs[6]  = mkv(OP_ILL, 3'd0, 3'd0, 16'h0,    16'h0,    16'h8888, 16'h8888, mk(4'b1111, 4'b1111, FS_LOAD,  0, 16'h0,    1));
    vecs[7]  = mkv(OP_SWP, 3'd2, 3'd2, 16'h0,    16'h4242, 16'h4242, 16'h4242, mk(4'b1111, 4'b1111, FS_LOAD,  0, 16'h0,    0));
    vecs[8]  = mkv(OP_MOV, 3'd6, 3'd6, 16'h0,    16'h0BEE, 16'h0BEE, 16'h0BEE, mk(4'b1111, 4'b1101, FS_LOAD,  1, 16'h0BEE, 0));
    vecs[9]  = mkv(OP_INC, 3'd0, 3'd0, 16'h0,    16'h0,    16'h00FF, 16'h0100, mk(4'b0111, 4'b1111, FS_INC,   1, 16'h0,    0));
    vecs[10] = mkv(OP_LDI, 3'd7, 3'd0, 16'h0,    16'h0,    16'h3C3C, 16'h0000, mk(4'b1111, 4'b1110, FS_LOAD,  1, 16'h0,    0));

    for (int k = 0; k < 8; k++) rf[k] <= '0;
    rstn          = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = OP_NOP;
    cif.cmd_dst   = '0;
    cif.cmd_src   = '0;
    cif.cmd_imm   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_regsel", RegSel, 4'b1111);
    chk("rst_scrsel", ScrSel, 4'b1111);
    chk("rst_funsel", FunSel, 3'b010);
    chk("rst_outasel", OutASel, 0);
    chk("rst_outbsel", OutBSel, 0);
    chk("rst_ready", cif.cmd_ready, 0);
    chk("rst_done", cif.done, 0);
    chk("rst_err", cif.err, 0);
    chk("rst_I", I, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cif.cmd_ready, 1);

    // Single-cycle ops from the vector table
    foreach (vecs[n]) begin
      if (vecs[n].op == OP_MOV || vecs[n].op == OP_SWP) rf[vecs[n].src] <= vecs[n].pre_src;
      rf[vecs[n].dst] <= vecs[n].pre_dst;
      drive(vecs[n].op, vecs[n].dst, vecs[n].src, vecs[n].imm, vecs[n].e);
      wait_idle();
      chk($sformatf("vec%0d_result", n), rf[vecs[n].dst], vecs[n].res);
    end

    // Swap R2 <-> S3: three busy cycles, one done pulse
    rf[1] <= 16'h0011;
    rf[6] <= 16'h0022;
    d0 = dones;
    busy = 0;
    drive(OP_SWP, 3'd6, 3'd1, 16'h0, mk(4'b1011, 4'b1111, FS_LOAD, 1, 16'h0022, 0));
    while (cif.cmd_ready !== 1'b1 && busy < 10) begin
      busy++;
      if (busy == 1) begin
        chk("swp_rd_outasel", OutASel, 3'd1);
        chk("swp_rd_outbsel", OutBSel, 3'd6);
        chk("swp_rd_regsel", RegSel, 4'b1111);
        chk("swp_rd_scrsel", ScrSel, 4'b1111);
      end
      if (busy == 2) begin
        chk("swp_w1_regsel", RegSel, 4'b1111);
        chk("swp_w1_scrsel", ScrSel, 4'b1101);
        chk("swp_w1_funsel", FunSel, FS_LOAD);
        chk("swp_w1_I", I, 16'h0011);
      end
      @(negedge clk);
    end
    chk("swp_busy_cycles", busy, 3);
    chk("swp_r2", rf[1], 16'h0022);
    chk("swp_s3", rf[6], 16'h0011);
    chk("swp_done_pulses", dones - d0, 1);

    // Back-to-back valid: accepted only every second cycle
    accepts = 0;
    cif.cmd_op    = OP_LDI;
    cif.cmd_dst   = 3'd4;
    cif.cmd_src   = 3'd0;
    cif.cmd_imm   = 16'h0C0C;
    cif.cmd_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (cif.cmd_ready === 1'b1) begin
        accepts++;
        sb.push_back(mk(4'b1111, 4'b0111, FS_LOAD, 1, 16'h0C0C, 0));
      end
      if (c < 7) @(negedge clk);
    end
    cif.cmd_valid = 1'b0;
    chk("b2b_accepts", accepts, 4);
    wait_idle();
    chk("b2b_s1", rf[4], 16'h0C0C);

    // Reset during SWP_W1: first write stays, no rollback
    rf[0] <= 16'hAAAA;
    rf[7] <= 16'hBBBB;
    drive(OP_SWP, 3'd7, 3'd0, 16'h0, mk(4'b0111, 4'b1111, FS_LOAD, 1, 16'hBBBB, 0));
    @(negedge clk);
    chk("rstmid_w1_scrsel", ScrSel, 4'b1110);
    rstn = 1'b0;
    @(negedge clk);
    chk("rstmid_regsel", RegSel, 4'b1111);
    chk("rstmid_scrsel", ScrSel, 4'b1111);
    chk("rstmid_ready", cif.cmd_ready, 0);
    chk("rstmid_done", cif.done, 0);
    chk("rstmid_s4", rf[7], 16'hAAAA);
    chk("rstmid_r1", rf[0], 16'hAAAA);
    sb.delete();
    rstn = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_after", cif.cmd_ready, 1);
    @(negedge clk);
    chk("rstmid_r1_hold", rf[0], 16'hAAAA);

    // Five commands including one swap
    rf[2] <= 16'h0202;
    drive(OP_LDI, 3'd1, 3'd0, 16'h0101, mk(4'b1011, 4'b1111, FS_LOAD, 1, 16'h0101, 0));
    wait_idle();
    drive(OP_INC, 3'd1, 3'd0, 16'h0, mk(4'b1011, 4'b1111, FS_INC, 1, 16'h0, 0));
    wait_idle();
    drive(OP_SWP, 3'd2, 3'd1, 16'h0, mk(4'b1011, 4'b1111, FS_LOAD, 1, 16'h0202, 0));
    wait_idle();
    drive(OP_DEC, 3'd5, 3'd0, 16'h0, mk(4'b1111, 4'b1011, FS_DEC, 1, 16'h0, 0));
    wait_idle();
    drive(OP_NOP, 3'd0, 3'd0, 16'h0, mk(4'b1111, 4'b1111, FS_LOAD, 0, 16'h0, 0));
    wait_idle();
    chk("seq_r2", rf[1], 16'h0202);
    chk("seq_r3", rf[2], 16'h0102);
`ifdef RFSEQ_STATS_EN
    chk("stats_cmd_count", cmd_count, 16'd5);
    chk("stats_swp_count", swp_count, 8'd1);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Command-driven master for the 8-entry register file (R1-R4, S1-S4); owns its write side (FunSel, RegSel, ScrSel, I) and read selects (OutASel, OutBSel).
- Accepts one micro-op per valid/ready handshake and expands it into the register-file control sequence: single-cycle ops, or a 3-cycle swap through internal temporaries.
- Sits between the instruction decoder and the register file.

Parameters:
- DATA_W, 16, register-file data width; width of I, OutA, OutB, cmd_imm.

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer idle and able to accept.
- cmd_op  in  3  opcode: 000 NOP, 001 CLR, 010 LDI, 011 INC, 100 DEC, 101 MOV, 110 SWP, 111 illegal.
- cmd_dst  in  3  destination address: 0-3 = R1-R4, 4-7 = S1-S4.
- cmd_src  in  3  source address, same encoding; used by MOV and SWP.
- cmd_imm  in  DATA_W  immediate for LDI.
- done  out  1  one-cycle pulse in the cycle of the command's final write strobe.
- err  out  1  one-cycle pulse when opcode 111 is accepted.
- FunSel  out  3  to register file.
- RegSel  out  4  active-low; bit3 = R1 ... bit0 = R4.
- ScrSel  out  4  active-low; bit3 = S1 ... bit0 = S4.
- OutASel  out  3  to register file.
- OutBSel  out  3  to register file.
- I  out  DATA_W  register-file write data.
- OutA  in  DATA_W  register-file read port A.
- OutB  in  DATA_W  register-file read port B.

Behaviour:
- FunSel encoding: DEC 000, INC 001, LOAD 010, CLEAR 011.
- Write-enable rule:
  - A write enables exactly one bit of RegSel or ScrSel, low.
  - All other cycles drive RegSel = ScrSel = 4'b1111.
- Output timing:
  - All outputs are registered except I.
  - I is a combinational mux:
    - OutA during a MOV write.
    - imm_q during LDI.
    - tmp_a or tmp_b during swap writes.
    - 0 otherwise.
- Reset (Reset low at a rising edge, including mid-operation):
  - state = IDLE; RegSel = ScrSel = 1111; FunSel = 010.
  - OutASel = OutBSel = 0; cmd_ready = done = err = 0; tmp_a = tmp_b = imm_q = 0.
  - A swap interrupted between its writes leaves the first write in place; there is no rollback.
  - cmd_ready rises at the first edge with Reset high.
- States: IDLE, EXEC, SWP_RD, SWP_W1, SWP_W2.
- Handshake:
  - Transfer occurs at an edge where cmd_valid && cmd_ready; op, src, dst and imm are latched.
  - cmd_ready is 0 from the accepting edge until the edge that returns to IDLE.
- IDLE -> EXEC (NOP, CLR, LDI, INC, DEC, MOV, 111):
  - During EXEC the write strobe for dst is driven with FunSel = CLEAR, LOAD, INC, DEC or LOAD respectively.
  - MOV drives OutASel = src and I = OutA.
  - NOP and 111 drive no write.
  - done = 1 in EXEC for every opcode; err = 1 in EXEC for 111.
  - EXEC -> IDLE. Cost is 2 cycles per command.
- IDLE -> SWP_RD (SWP, src != dst):
  - SWP_RD: OutASel = src, OutBSel = dst, no write.
  - SWP_W1: tmp_a = OutA and tmp_b = OutB are captured at entry; LOAD dst with I = tmp_a.
  - SWP_W2: LOAD src with I = tmp_b; done = 1.
  - SWP_W2 -> IDLE. Cost is 4 cycles.
- SWP with src == dst is executed as a NOP through EXEC.
- MOV with src == dst performs the load; value is unchanged.
- INC/DEC wrap at the register's own width; the sequencer adds no saturation.
- cmd_valid while busy is ignored; the command is held by the initiator.

Optional Feature:
- Macro RFSEQ_STATS_EN.
- Defined:
  - Extra output cmd_count (16-bit), reset to 0.
  - Increments on every done pulse and saturates at 16'hFFFF.
  - A separate 8-bit swp_count counts completed swaps, also saturating.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package rfseq_pkg:
  - opcode constants.
  - FunSel constants (DEC, INC, LOAD, CLEAR).
  - state encoding.
  - NONE_SEL = 4'b1111.
  - Function mapping a 3-bit address to the (RegSel, ScrSel) active-low one-cold pair.
- One natural sub-module: rfseq_sel_decode, which holds that address-to-select decode and is shared by all write states.

Test Plan:
- LDI dst=2 imm=16'hA5A5 -> one cycle with RegSel = 1101, ScrSel = 1111, FunSel = 010, I = A5A5, done = 1; R3 reads A5A5 afterwards.
- MOV src=0 dst=5 with R1 = 16'h1234 -> OutASel = 0, ScrSel = 1011, I = 1234; S2 = 1234.
- SWP src=1 dst=6 with R2 = 0x0011, S3 = 0x0022 -> exactly 3 busy cycles (SWP_RD, SWP_W1, SWP_W2), then cmd_ready = 1; R2 = 0x0022, S3 = 0x0011; done pulses once.
- INC dst=3 with R4 = 16'hFFFF -> FunSel = 001 with RegSel = 1110; R4 wraps to 0000. Opcode 111 -> err = 1, done = 1, no select low.
- Reset low during SWP_W1 -> next cycle state IDLE, RegSel = ScrSel = 1111, cmd_ready = 0; cmd_ready = 1 one edge after Reset goes high. Back-to-back valid is accepted only every 2 cycles.
- With RFSEQ_STATS_EN, 5 commands including 1 SWP -> cmd_count = 5, swp_count = 1.
